// File: rtl/vga_timing_pkg.sv
// ----------------------------------------------------------------------------
// vga_timing_pkg
// Shared constants for the 640x480@60 Hz raster:
//   - horizontal/vertical segment lengths and the derived totals
//   - sync pulse start/end positions
//   - the window occupied by the start/game-over printers
//   - the packed record carried through the sync delay line and its idle value
// ----------------------------------------------------------------------------
package vga_timing_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;   // 800

    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;   // 525

    // Sync pulses occupy [START, END)
    localparam int H_SYNC_START = H_VISIBLE + H_FRONT;                  // 656
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;                // 752
    localparam int V_SYNC_START = V_VISIBLE + V_FRONT;                  // 490
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;                // 492

    // Centred 256x128 window used by the start/game-over printers, [START, END)
    localparam int PRINT_X_START = 192;
    localparam int PRINT_X_END   = 448;
    localparam int PRINT_Y_START = 176;
    localparam int PRINT_Y_END   = 304;

    // Raw decode bundle; field order fixes the packed layout {hs, vs, vo}
    typedef struct packed {
        logic hs;
        logic vs;
        logic vo;
    } sync_bits_t;

    // Inactive levels: both syncs high (active-low), video off
    localparam sync_bits_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, vo: 1'b0};

endpackage

// File: rtl/sync_delay_line.sv
// ----------------------------------------------------------------------------
// sync_delay_line
// Fixed-depth shift register that aligns the raw sync/video decodes with the
// registered pixel pipeline. DEPTH = 0 degenerates to a wire.
// Ports:
//   clk_i   in   clock, rising edge
//   rst_i   in   synchronous, active-high; loads every stage with RESET_VALUE
//   data_i  in   WIDTH-bit value entering the line
//   data_o  out  data_i delayed by DEPTH cycles
// ----------------------------------------------------------------------------
module sync_delay_line #(
    parameter int               WIDTH       = 3,
    parameter int               DEPTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = 3'b110
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    generate
        if (DEPTH == 0) begin : g_bypass
            // No stages: clock and reset are intentionally left unused
            logic unused_s;
            assign unused_s = clk_i ^ rst_i;
            assign data_o   = data_i;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage_q [DEPTH];

            // Shift chain; reset loads the idle value into every stage
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= RESET_VALUE;
                    end
                end else begin
                    stage_q[0] <= data_i;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign data_o = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_generator.sv
// ----------------------------------------------------------------------------
// vga_timing_generator
// Free-running raster timing generator for 640x480@60 Hz on a 25 MHz clock.
// Ports:
//   clock_25    in   pixel clock, rising edge
//   reset       in   synchronous, active-high; aborts the frame
//   X, Y        out  registered pixel coordinates (0..799, 0..524)
//   hsync       out  active-low, delayed by SYNC_DELAY
//   vsync       out  active-low, delayed by SYNC_DELAY
//   video_on    out  visible-area flag, delayed by SYNC_DELAY
//   frame_tick  out  high during the last pixel of the frame (799,524)
//   blink       out  toggles every BLINK_FRAMES frames
// ----------------------------------------------------------------------------
module vga_timing_generator #(
    parameter int PIXEL_DISPLAY_BIT = 9,
    parameter int H_VISIBLE         = vga_timing_pkg::H_VISIBLE,
    parameter int H_FRONT           = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC            = vga_timing_pkg::H_SYNC,
    parameter int H_BACK            = vga_timing_pkg::H_BACK,
    parameter int V_VISIBLE         = vga_timing_pkg::V_VISIBLE,
    parameter int V_FRONT           = vga_timing_pkg::V_FRONT,
    parameter int V_SYNC            = vga_timing_pkg::V_SYNC,
    parameter int V_BACK            = vga_timing_pkg::V_BACK,
    parameter int SYNC_DELAY        = 1,
    parameter int BLINK_FRAMES      = 30
) (
    input  logic                       clock_25,
    input  logic                       reset,
    output logic [PIXEL_DISPLAY_BIT:0] X,
    output logic [PIXEL_DISPLAY_BIT:0] Y,
    output logic                       hsync,
    output logic                       vsync,
    output logic                       video_on,
    output logic                       frame_tick,
    output logic                       blink
);

    import vga_timing_pkg::*;

    localparam int XW = PIXEL_DISPLAY_BIT + 1;

    localparam logic [PIXEL_DISPLAY_BIT:0] X_LAST   = XW'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [PIXEL_DISPLAY_BIT:0] X_VIS    = XW'(H_VISIBLE);
    localparam logic [PIXEL_DISPLAY_BIT:0] HS_START = XW'(H_VISIBLE + H_FRONT);
    localparam logic [PIXEL_DISPLAY_BIT:0] HS_END   = XW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [PIXEL_DISPLAY_BIT:0] Y_LAST   = XW'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [PIXEL_DISPLAY_BIT:0] Y_VIS    = XW'(V_VISIBLE);
    localparam logic [PIXEL_DISPLAY_BIT:0] VS_START = XW'(V_VISIBLE + V_FRONT);
    localparam logic [PIXEL_DISPLAY_BIT:0] VS_END   = XW'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [7:0]                 BLINK_LAST = 8'(BLINK_FRAMES - 1);

    logic [PIXEL_DISPLAY_BIT:0] x_q, x_d;
    logic [PIXEL_DISPLAY_BIT:0] y_q, y_d;
    logic                       frame_tick_q, frame_tick_d;
    logic [7:0]                 frame_cnt_q, frame_cnt_d;
    logic                       blink_q, blink_d;
    sync_bits_t                 raw_s;
    sync_bits_t                 dly_s;

    // Raster counters: X wraps every line, Y advances on the X wrap
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == Y_LAST) begin
                y_d = '0;
            end else begin
                y_d = y_q + 1'b1;
            end
        end else begin
            x_d = x_q + 1'b1;
        end
    end

    // frame_tick is registered from the next position so it is high exactly
    // while X/Y read the last pixel of the frame
    assign frame_tick_d = (x_d == X_LAST) && (y_d == Y_LAST);

    // Frame counter and blink advance on the same edge that wraps X/Y
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        blink_d     = blink_q;
        if (frame_tick_q) begin
            if (frame_cnt_q == BLINK_LAST) begin
                frame_cnt_d = 8'd0;
                blink_d     = ~blink_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 8'd1;
            end
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    // Raw decodes of the current position, before pipeline alignment
    always_comb begin
        raw_s    = SYNC_IDLE;
        raw_s.hs = ~((x_q >= HS_START) && (x_q < HS_END));
        raw_s.vs = ~((y_q >= VS_START) && (y_q < VS_END));
        raw_s.vo = (x_q < X_VIS) && (y_q < Y_VIS);
    end

    // State registers; reset has priority over all counting
    always_ff @(posedge clock_25) begin
        if (reset) begin
            x_q          <= '0;
            y_q          <= '0;
            frame_tick_q <= 1'b0;
            frame_cnt_q  <= 8'd0;
            blink_q      <= 1'b0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            frame_tick_q <= frame_tick_d;
            frame_cnt_q  <= frame_cnt_d;
            blink_q      <= blink_d;
        end
    end

    sync_delay_line #(
        .WIDTH       ($bits(sync_bits_t)),
        .DEPTH       (SYNC_DELAY),
        .RESET_VALUE (SYNC_IDLE)
    ) u_sync_delay (
        .clk_i  (clock_25),
        .rst_i  (reset),
        .data_i (raw_s),
        .data_o (dly_s)
    );

    assign X          = x_q;
    assign Y          = y_q;
    assign hsync      = dly_s.hs;
    assign vsync      = dly_s.vs;
    assign video_on   = dly_s.vo;
    assign frame_tick = frame_tick_q;
    assign blink      = blink_q;

endmodule

// File: tb/tb_vga_timing_generator.sv
// ----------------------------------------------------------------------------
// tb_vga_timing_generator
// Four builds share clock and reset:
//   u_main : default geometry, SYNC_DELAY=1, BLINK_FRAMES=30
//   u_d0   : default geometry, SYNC_DELAY=0
//   u_d3   : default geometry, SYNC_DELAY=3
//   u_sm   : 16x8 raster (frame = 128 cycles), SYNC_DELAY=1, BLINK_FRAMES=2,
//            so frame-level behaviour is reachable in a short run
// t counts rising edges since the last edge with reset high.
// ----------------------------------------------------------------------------
module tb_vga_timing_generator;

    logic clk = 1'b0;
    logic reset;

    always #20 clk = ~clk;

    logic [9:0] x_m, y_m;
    logic       hsync_m, vsync_m, video_on_m, frame_tick_m, blink_m;

    logic [9:0] x_d0_unused, y_d0_unused;
    logic       hsync_d0, video_on_d0;
    logic       vsync_d0_unused, frame_tick_d0_unused, blink_d0_unused;

    logic [9:0] x_d3_unused, y_d3_unused;
    logic       hsync_d3, vsync_d3, video_on_d3;
    logic       frame_tick_d3_unused, blink_d3_unused;

    logic [9:0] x_sm, y_sm;
    logic       hsync_sm_unused, video_on_sm_unused;
    logic       vsync_sm, frame_tick_sm, blink_sm;

    vga_timing_generator u_main (
        .clock_25 (clk), .reset (reset), .X (x_m), .Y (y_m),
        .hsync (hsync_m), .vsync (vsync_m), .video_on (video_on_m),
        .frame_tick (frame_tick_m), .blink (blink_m)
    );

    vga_timing_generator #(.SYNC_DELAY(0)) u_d0 (
        .clock_25 (clk), .reset (reset), .X (x_d0_unused), .Y (y_d0_unused),
        .hsync (hsync_d0), .vsync (vsync_d0_unused), .video_on (video_on_d0),
        .frame_tick (frame_tick_d0_unused), .blink (blink_d0_unused)
    );

    vga_timing_generator #(.SYNC_DELAY(3)) u_d3 (
        .clock_25 (clk), .reset (reset), .X (x_d3_unused), .Y (y_d3_unused),
        .hsync (hsync_d3), .vsync (vsync_d3), .video_on (video_on_d3),
        .frame_tick (frame_tick_d3_unused), .blink (blink_d3_unused)
    );

    vga_timing_generator #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(2),
        .SYNC_DELAY(1), .BLINK_FRAMES(2)
    ) u_sm (
        .clock_25 (clk), .reset (reset), .X (x_sm), .Y (y_sm),
        .hsync (hsync_sm_unused), .vsync (vsync_sm), .video_on (video_on_sm_unused),
        .frame_tick (frame_tick_sm), .blink (blink_sm)
    );

    int tests = 0;
    int fails = 0;
    int t     = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s (t=%0d): got %0d, expected %0d", name, t, act, exp);
        end
    endtask

    // Expected values at t edges after release, default geometry
    typedef struct {
        int   t;
        int   x;
        int   y;
        logic hs1;
        logic vo1;
        logic hs0;
        logic vo0;
        logic hs3;
        logic vo3;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    initial begin
        int n;
        int vi;
        int hs_low_m, vo_hi_m, hs_low_d3, vs_low_m, tick_m;
        int vs_low_sm, ticks_sm, last_tick;

        //                t     x    y  hs1   vo1   hs0   vo0   hs3   vo3
        vecs[0]  = '{    1,    1,   0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{    2,    2,   0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{    3,    3,   0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[3]  = '{  640,  640,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[4]  = '{  641,  641,   0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{  643,  643,   0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{  656,  656,   0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{  657,  657,   0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{  659,  659,   0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{  752,  752,   0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{  753,  753,   0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{  755,  755,   0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{  800,    0,   1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{  801,    1,   1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[14] = '{  803,    3,   1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[15] = '{ 2257,  657,   2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        // Power-up reset, then run to (300,2) of the default raster
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        while (!(x_m == 10'd300 && y_m == 10'd2) && n < 5000) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check("edges_to_300_2", n, 1900);
        // 14 small-raster frames elapsed: blink toggled 7 times
        check("sm_blink_before_reset", int'(blink_sm), 1);

        // Mid-frame reset held for 5 edges
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_x",        int'(x_m),         0);
            check("rst_y",        int'(y_m),         0);
            check("rst_hsync",    int'(hsync_m),     1);
            check("rst_vsync",    int'(vsync_m),     1);
            check("rst_video_on", int'(video_on_m),  0);
            check("rst_blink",    int'(blink_m),     0);
            check("rst_d3_hsync", int'(hsync_d3),    1);
            check("rst_d3_vsync", int'(vsync_d3),    1);
            check("rst_d3_vo",    int'(video_on_d3), 0);
            check("rst_sm_x",     int'(x_sm),        0);
            check("rst_sm_blink", int'(blink_sm),    0);
            check("rst_sm_tick",  int'(frame_tick_sm), 0);
        end
        reset = 1'b0;

        vi = 0;
        hs_low_m = 0; vo_hi_m = 0; hs_low_d3 = 0; vs_low_m = 0; tick_m = 0;
        vs_low_sm = 0; ticks_sm = 0; last_tick = -1;

        for (int tt = 1; tt <= 2400; tt++) begin
            @(posedge clk);
            @(negedge clk);
            t = tt;

            if (vi < NV && vecs[vi].t == tt) begin
                check("vec_x",     int'(x_m),         vecs[vi].x);
                check("vec_y",     int'(y_m),         vecs[vi].y);
                check("vec_hs1",   int'(hsync_m),     int'(vecs[vi].hs1));
                check("vec_vo1",   int'(video_on_m),  int'(vecs[vi].vo1));
                check("vec_hs0",   int'(hsync_d0),    int'(vecs[vi].hs0));
                check("vec_vo0",   int'(video_on_d0), int'(vecs[vi].vo0));
                check("vec_hs3",   int'(hsync_d3),    int'(vecs[vi].hs3));
                check("vec_vo3",   int'(video_on_d3), int'(vecs[vi].vo3));
                vi++;
            end

            // One full line of the default raster
            if (tt >= 800 && tt < 1600) begin
                if (!hsync_m)    hs_low_m++;
                if (video_on_m)  vo_hi_m++;
                if (!hsync_d3)   hs_low_d3++;
            end
            if (!vsync_m)     vs_low_m++;
            if (frame_tick_m) tick_m++;

            // Small raster: line/frame wrap and blink corner points
            case (tt)
                111: begin
                    check("sm_x_15_6", int'(x_sm), 15);
                    check("sm_y_15_6", int'(y_sm), 6);
                    check("sm_tick_15_6", int'(frame_tick_sm), 0);
                end
                112: begin
                    check("sm_x_wrap_line", int'(x_sm), 0);
                    check("sm_y_wrap_line", int'(y_sm), 7);
                end
                127: begin
                    check("sm_x_last", int'(x_sm), 15);
                    check("sm_y_last", int'(y_sm), 7);
                    check("sm_tick_last", int'(frame_tick_sm), 1);
                end
                128: begin
                    check("sm_x_wrap_frame", int'(x_sm), 0);
                    check("sm_y_wrap_frame", int'(y_sm), 0);
                    check("sm_tick_after", int'(frame_tick_sm), 0);
                end
                255: check("sm_blink_pre_2nd",  int'(blink_sm), 0);
                256: check("sm_blink_post_2nd", int'(blink_sm), 1);
                511: check("sm_blink_pre_4th",  int'(blink_sm), 1);
                512: check("sm_blink_post_4th", int'(blink_sm), 0);
                767: check("sm_blink_pre_6th",  int'(blink_sm), 0);
                768: check("sm_blink_post_6th", int'(blink_sm), 1);
                default: ;
            endcase

            if (tt >= 128 && tt < 256 && !vsync_sm) vs_low_sm++;
            if (frame_tick_sm) begin
                ticks_sm++;
                if (last_tick >= 0) check("sm_frame_period", tt - last_tick, 128);
                last_tick = tt;
            end
        end

        check("vectors_applied",      vi,        NV);
        check("line_hsync_low",       hs_low_m,  96);
        check("line_video_on_high",   vo_hi_m,   640);
        check("line_d3_hsync_low",    hs_low_d3, 96);
        check("main_vsync_low_early", vs_low_m,  0);
        check("main_no_frame_tick",   tick_m,    0);
        check("sm_vsync_low_frame",   vs_low_sm, 16);
        check("sm_tick_count",        ticks_sm,  18);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
